reference_xcorr: RTL and testbench
==================================

# reference_xcorr

Correlates the stored reference against one block of received samples. For each correlation it does three things:
- issues sample indices 0..BUFFER_LENGTH-1 to the reference buffer;
- consumes the returned reference I/Q, paired one-for-one with an incoming received I/Q stream;
- accumulates the complex product conj(ref)·rx and presents a single complex result with a valid/ready handshake.

It sits directly downstream of the reference buffer and upstream of the CAF magnitude/peak logic.

## Interface

- SAMPLE_BITS, 12, signed width of ref/rx I and Q
- INDEX_BITS, 10, reference index width
- BUFFER_LENGTH, 1000, samples per correlation; 1 ≤ BUFFER_LENGTH ≤ 2^INDEX_BITS
- OUT_BITS, 2*SAMPLE_BITS+1+INDEX_BITS, signed result width (derived, not overridden)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a correlation; honoured only in IDLE
- busy  out  1  high in any state other than IDLE
- ref_index_tvalid  out  1  index request valid
- ref_index_tdata  out  INDEX_BITS  index requested
- ref_index_tready  in  1  buffer accepts index
- ref_data_tvalid  in  1  reference sample valid
- ref_i, ref_q  in  SAMPLE_BITS  reference sample, signed
- ref_data_tready  out  1  block consumes reference sample
- rx_tvalid  in  1  received sample valid
- rx_i, rx_q  in  SAMPLE_BITS  received sample, signed
- rx_tready  out  1  block consumes received sample
- out_tvalid  out  1  result valid
- out_re, out_im  out  OUT_BITS  accumulated result, signed
- out_tready  in  1  downstream accepts result

## Operation

**FSM states:** IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start. The accumulator, index counter and pair counter all clear to 0.
- RUN → DRAIN when the pair counter reaches BUFFER_LENGTH, i.e. the final pair fires.
- DRAIN → DONE once the final product has been accumulated.
- DONE → IDLE on out_tvalid && out_tready.
- start outside IDLE is ignored.

**Index issue:**
- In RUN, ref_index_tvalid=1 while index count < BUFFER_LENGTH.
- ref_index_tdata holds the count and advances by 1 on each ref_index_tvalid && ref_index_tready.
- ref_index_tvalid drops the cycle after index BUFFER_LENGTH-1 is accepted.
- Indices are issued strictly ascending with no gaps or repeats.

**Pairing (RUN only; both readys are 0 elsewhere):**
- ref_data_tready = rx_tvalid && pairs < BUFFER_LENGTH.
- rx_tready = ref_data_tvalid && pairs < BUFFER_LENGTH.
- A pair fires when ref_data_tvalid && rx_tvalid; pairs then increments.
- The readys depend on the partner valid only. Valids never depend on readys.

**Arithmetic:**
- Stage 1 registers, from the fired pair:
  - re_p = ref_i·rx_i + ref_q·rx_q
  - im_p = ref_i·rx_q − ref_q·rx_i
  - Each is 2*SAMPLE_BITS+1 bits, signed, full precision.
- Stage 2 sign-extends both to OUT_BITS and adds them into the accumulator.
- Widths are chosen so overflow is impossible; no saturation and no rounding.

## Timing

- **Reset:** every output is 0 one cycle after rst is sampled high, and the state is IDLE. This applies at any point, including mid-RUN or in DONE; the partial result is discarded and out_tvalid is never asserted for it.
- **Start:** start sampled at cycle 0 gives busy=1, ref_index_tvalid=1 and ref_index_tdata=0 from cycle 1.
- **Result latency:** if the final pair fires at cycle f:
  - out_tvalid=1 at f+2;
  - out_re/out_im hold the final sum from f+2 onward.
- **Result hold:** out_tvalid, out_re and out_im are held stable until out_tready is sampled high.
- **Return to idle:** out_tvalid=0 and busy=0 on the cycle after acceptance. out_re/out_im retain their value until the next start.
- **Back-to-back:** a start arriving in the cycle that out_tvalid is accepted is ignored. The earliest new start is accepted the cycle after that.
- **Ordering:** reference data may arrive with any latency after its index and may stall arbitrarily. Result values must not depend on timing.

## Test plan

- **Constant:** BUFFER_LENGTH=8, ref=(1,0), rx=(3,−2), both always valid → indices 0..7 issued once each; out_re=24, out_im=−16.
- **Conjugate sign:** BUFFER_LENGTH=4.
  - ref=(0,1), rx=(0,1) → out_re=4, out_im=0.
  - ref=(0,1), rx=(1,0) → out_re=0, out_im=−4.
- **Full scale:** SAMPLE_BITS=12, BUFFER_LENGTH=1024, all inputs −2048 → out_re=2^33, out_im=0, no wrap.
- **Backpressure:** constant case with rx_tvalid toggling every cycle, ref_index_tready random, and ref data delayed 3 cycles → same 24/−16; pair count exactly 8.
- **Output stall:** out_tready low 10 cycles with start pulsed → result and out_tvalid stable, busy=1, start ignored; on release, busy=0 the next cycle.
- **Reset mid-run:** rst after 3 pairs → all outputs 0 next cycle. A fresh start then yields the clean constant-case result.

Source files
------------

// File: rtl/reference_xcorr.sv
// ---------------------------------------------------------------------------
// reference_xcorr
//
// Correlates the stored reference against one block of received samples.
// On start it walks reference indices 0..BUFFER_LENGTH-1 out to the
// reference buffer. It pairs each returned reference sample one-for-one with
// the received sample stream, and accumulates conj(ref) * rx. The single
// complex sum is then presented on a valid/ready output.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start                     one-cycle request, honoured only when idle
//   busy                      high whenever not idle
//   ref_index_t{valid,data,ready}  index requests to the reference buffer
//   ref_data_t{valid,ready}, ref_i, ref_q   returned reference samples
//   rx_t{valid,ready}, rx_i, rx_q           received samples
//   out_t{valid,ready}, out_re, out_im      accumulated complex result
// ---------------------------------------------------------------------------
module reference_xcorr #(
    parameter int SAMPLE_BITS   = 12,
    parameter int INDEX_BITS    = 10,
    parameter int BUFFER_LENGTH = 1000,
    localparam int OUT_BITS     = 2*SAMPLE_BITS + 1 + INDEX_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          ref_index_tvalid,
    output logic [INDEX_BITS-1:0]         ref_index_tdata,
    input  logic                          ref_index_tready,
    input  logic                          ref_data_tvalid,
    input  logic signed [SAMPLE_BITS-1:0] ref_i,
    input  logic signed [SAMPLE_BITS-1:0] ref_q,
    output logic                          ref_data_tready,
    input  logic                          rx_tvalid,
    input  logic signed [SAMPLE_BITS-1:0] rx_i,
    input  logic signed [SAMPLE_BITS-1:0] rx_q,
    output logic                          rx_tready,
    output logic                          out_tvalid,
    output logic signed [OUT_BITS-1:0]    out_re,
    output logic signed [OUT_BITS-1:0]    out_im,
    input  logic                          out_tready
);

    localparam int PROD_BITS = 2*SAMPLE_BITS + 1;
    // One extra bit so the counters can hold BUFFER_LENGTH == 2^INDEX_BITS.
    localparam int CNT_BITS  = INDEX_BITS + 1;
    localparam logic [CNT_BITS-1:0] LEN = CNT_BITS'(BUFFER_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_BITS-1:0]         idx_q, idx_d;
    logic [CNT_BITS-1:0]         pairs_q, pairs_d;
    logic                        p_valid_q;
    logic signed [PROD_BITS-1:0] re_p_q, im_p_q, re_p_d, im_p_d;
    logic signed [OUT_BITS-1:0]  acc_re_q, acc_im_q, acc_re_d, acc_im_d;

    logic                        run;
    logic                        pairs_left;
    logic                        idx_fire;
    logic                        pair_fire;
    logic signed [PROD_BITS-1:0] ri_x, rq_x, xi_x, xq_x;

    assign run        = (state_q == S_RUN);
    assign pairs_left = (pairs_q < LEN);

    assign ref_index_tvalid = run && (idx_q < LEN);
    assign ref_index_tdata  = idx_q[INDEX_BITS-1:0];
    assign idx_fire         = ref_index_tvalid && ref_index_tready;

    // Each ready looks only at the partner's valid, so a pair is consumed
    // from both streams in the same cycle or from neither.
    assign ref_data_tready = run && pairs_left && rx_tvalid;
    assign rx_tready       = run && pairs_left && ref_data_tvalid;
    assign pair_fire       = run && pairs_left && ref_data_tvalid && rx_tvalid;

    assign busy       = (state_q != S_IDLE);
    assign out_tvalid = (state_q == S_DONE);
    assign out_re     = acc_re_q;
    assign out_im     = acc_im_q;

    // Sign-extend the operands before multiplying so every product and sum
    // is computed at full precision.
    assign ri_x = PROD_BITS'(ref_i);
    assign rq_x = PROD_BITS'(ref_q);
    assign xi_x = PROD_BITS'(rx_i);
    assign xq_x = PROD_BITS'(rx_q);

    // conj(ref) * rx
    assign re_p_d = ri_x * xi_x + rq_x * xq_x;
    assign im_p_d = ri_x * xq_x - rq_x * xi_x;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pairs_d  = pairs_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;

        if (p_valid_q) begin
            acc_re_d = acc_re_q + OUT_BITS'(re_p_q);
            acc_im_d = acc_im_q + OUT_BITS'(im_p_q);
        end
        if (idx_fire) begin
            idx_d = idx_q + 1'b1;
        end
        if (pair_fire) begin
            pairs_d = pairs_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    idx_d    = '0;
                    pairs_d  = '0;
                    acc_re_d = '0;
                    acc_im_d = '0;
                end
            end
            S_RUN: begin
                if (pair_fire && (pairs_d == LEN)) begin
                    state_d = S_DRAIN;
                end
            end
            // DRAIN is entered with the final product sitting in stage 1.
            // It is added this cycle, so the sum is complete on entry to DONE.
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (out_tready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pairs_q   <= '0;
            p_valid_q <= 1'b0;
            re_p_q    <= '0;
            im_p_q    <= '0;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pairs_q   <= pairs_d;
            p_valid_q <= pair_fire;
            if (pair_fire) begin
                re_p_q <= re_p_d;
                im_p_q <= im_p_d;
            end
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
        end
    end

endmodule

// File: tb/tb_reference_xcorr.sv
// ---------------------------------------------------------------------------
// tb_reference_xcorr
//
// Scoreboard bench for reference_xcorr. The sequencer fills the reference
// memory and the rx sequence. It computes the expected complex sum with plain
// integer arithmetic and queues it, then pulses start. A buffer/stream driver
// answers index requests with programmable latency and backpressure. A
// monitor pops and compares on every accepted result. A second instance
// with BUFFER_LENGTH=1024 runs the full-scale case.
// ---------------------------------------------------------------------------
module tb_reference_xcorr;

    localparam int SB    = 12;
    localparam int IB    = 10;
    localparam int BL    = 8;
    localparam int OB    = 2*SB + 1 + IB;
    localparam int FS_BL = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic                 busy, ref_index_tvalid, ref_index_tready;
    logic [IB-1:0]        ref_index_tdata;
    logic                 ref_data_tvalid, ref_data_tready;
    logic signed [SB-1:0] ref_i, ref_q, rx_i, rx_q;
    logic                 rx_tvalid, rx_tready;
    logic                 out_tvalid, out_tready;
    logic signed [OB-1:0] out_re, out_im;

    logic                 fs_start = 1'b0;
    logic                 fs_busy, fs_ref_index_tvalid, fs_ref_data_tready, fs_rx_tready;
    logic [IB-1:0]        fs_ref_index_tdata;
    logic                 fs_out_tvalid;
    logic signed [OB-1:0] fs_out_re, fs_out_im;
    logic signed [SB-1:0] fs_sample;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    reference_xcorr #(.SAMPLE_BITS(SB), .INDEX_BITS(IB), .BUFFER_LENGTH(BL)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .ref_index_tvalid(ref_index_tvalid), .ref_index_tdata(ref_index_tdata),
        .ref_index_tready(ref_index_tready),
        .ref_data_tvalid(ref_data_tvalid), .ref_i(ref_i), .ref_q(ref_q),
        .ref_data_tready(ref_data_tready),
        .rx_tvalid(rx_tvalid), .rx_i(rx_i), .rx_q(rx_q), .rx_tready(rx_tready),
        .out_tvalid(out_tvalid), .out_re(out_re), .out_im(out_im),
        .out_tready(out_tready)
    );

    assign fs_sample = -12'sd2048;

    reference_xcorr #(.SAMPLE_BITS(SB), .INDEX_BITS(IB), .BUFFER_LENGTH(FS_BL)) dut_fs (
        .clk(clk), .rst(rst), .start(fs_start), .busy(fs_busy),
        .ref_index_tvalid(fs_ref_index_tvalid), .ref_index_tdata(fs_ref_index_tdata),
        .ref_index_tready(1'b1),
        .ref_data_tvalid(1'b1), .ref_i(fs_sample), .ref_q(fs_sample),
        .ref_data_tready(fs_ref_data_tready),
        .rx_tvalid(1'b1), .rx_i(fs_sample), .rx_q(fs_sample), .rx_tready(fs_rx_tready),
        .out_tvalid(fs_out_tvalid), .out_re(fs_out_re), .out_im(fs_out_im),
        .out_tready(1'b1)
    );

    // stimulus memories and driver modes
    int ref_i_m[BL];
    int ref_q_m[BL];
    int rx_i_m[BL];
    int rx_q_m[BL];
    bit tog = 1'b0;
    bit irand = 1'b0;
    int dly = 0;

    // scoreboard and bookkeeping
    longint exp_re_q[$];
    longint exp_im_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int n_results = 0;
    int pair_cnt = 0;
    int last_fire = 0;
    int exp_idx = 0;
    int idx_count = 0;
    int rx_ptr = 0;
    int pend_idx[$];
    int pend_due[$];

    task automatic check(input string nm, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Reference buffer model plus rx source. Handshakes are sampled on the
    // falling edge; inputs are updated just after the rising edge.
    initial begin : driver
        bit idx_f, rd_f, rx_f, clr;
        int idx_v;
        ref_index_tready = 1'b0;
        ref_data_tvalid  = 1'b0;
        ref_i = '0; ref_q = '0;
        rx_tvalid = 1'b0;
        rx_i = '0; rx_q = '0;
        forever begin
            @(negedge clk);
            idx_f = ref_index_tvalid && ref_index_tready;
            idx_v = int'(ref_index_tdata);
            rd_f  = ref_data_tvalid && ref_data_tready;
            rx_f  = rx_tvalid && rx_tready;
            clr   = rst || (start && !busy);
            @(posedge clk);
            #1;
            if (clr) begin
                exp_idx = 0; idx_count = 0; rx_ptr = 0;
                pend_idx.delete(); pend_due.delete();
            end else begin
                if (idx_f) begin
                    check("index_order", idx_v, exp_idx);
                    exp_idx++;
                    idx_count++;
                    pend_idx.push_back(idx_v);
                    pend_due.push_back(cyc + dly);
                end
                if (rd_f && pend_idx.size() > 0) begin
                    void'(pend_idx.pop_front());
                    void'(pend_due.pop_front());
                end
                if (rx_f) rx_ptr++;
            end
            ref_index_tready = irand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend_idx.size() > 0 && pend_due[0] <= cyc) begin
                ref_data_tvalid = 1'b1;
                ref_i = SB'(ref_i_m[pend_idx[0] % BL]);
                ref_q = SB'(ref_q_m[pend_idx[0] % BL]);
            end else begin
                ref_data_tvalid = 1'b0;
                ref_i = '0; ref_q = '0;
            end
            if (rx_ptr < BL) begin
                rx_tvalid = !tog || (cyc % 2 == 0);
                rx_i = SB'(rx_i_m[rx_ptr]);
                rx_q = SB'(rx_q_m[rx_ptr]);
            end else begin
                rx_tvalid = 1'b0;
                rx_i = '0; rx_q = '0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted result.
    initial begin : monitor
        bit prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
                pair_cnt = 0;
            end else begin
                if (ref_data_tvalid && ref_data_tready) begin
                    pair_cnt++;
                    last_fire = cyc;
                end
                if (out_tvalid && !prev_v) check("result_latency", cyc - last_fire, 2);
                if (out_tvalid && out_tready) begin
                    if (exp_re_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got re=%0d im=%0d, required no result",
                                 out_re, out_im);
                    end else begin
                        check("out_re", longint'(out_re), exp_re_q.pop_front());
                        check("out_im", longint'(out_im), exp_im_q.pop_front());
                    end
                    check("pair_count", pair_cnt, BL);
                    pair_cnt = 0;
                    n_results++;
                end
                prev_v = out_tvalid;
            end
        end
    end

    task automatic fill_const(input int ri, input int rq, input int xi, input int xq);
        for (int k = 0; k < BL; k++) begin
            ref_i_m[k] = ri; ref_q_m[k] = rq; rx_i_m[k] = xi; rx_q_m[k] = xq;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < BL; k++) begin
            ref_i_m[k] = int'($urandom_range(0, 4095)) - 2048;
            ref_q_m[k] = int'($urandom_range(0, 4095)) - 2048;
            rx_i_m[k]  = int'($urandom_range(0, 4095)) - 2048;
            rx_q_m[k]  = int'($urandom_range(0, 4095)) - 2048;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_idx_valid"}, ref_index_tvalid, 0);
        check({tag, "_idx_data"}, ref_index_tdata, 0);
        check({tag, "_ref_ready"}, ref_data_tready, 0);
        check({tag, "_rx_ready"}, rx_tready, 0);
        check({tag, "_out_valid"}, out_tvalid, 0);
        check({tag, "_out_re"}, longint'(out_re), 0);
        check({tag, "_out_im"}, longint'(out_im), 0);
    endtask

    // One correlation: model, queue, start, optional output stall, wait.
    task automatic run_case(input bit tog_i, input bit irand_i, input int dly_i, input int hold);
        longint er, ei;
        int base, waited;
        er = 0; ei = 0;
        for (int k = 0; k < BL; k++) begin
            er += longint'(ref_i_m[k]) * rx_i_m[k] + longint'(ref_q_m[k]) * rx_q_m[k];
            ei += longint'(ref_i_m[k]) * rx_q_m[k] - longint'(ref_q_m[k]) * rx_i_m[k];
        end
        exp_re_q.push_back(er);
        exp_im_q.push_back(ei);
        tog = tog_i; irand = irand_i; dly = dly_i;
        out_tready = (hold == 0);
        base = n_results;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_idx_valid", ref_index_tvalid, 1);
        check("start_idx_data", ref_index_tdata, 0);
        if (hold > 0) begin
            waited = 0;
            while (!out_tvalid && waited < 400) begin
                @(posedge clk); #1; waited++;
            end
            for (int k = 0; k < hold; k++) begin
                check("hold_valid", out_tvalid, 1);
                check("hold_busy", busy, 1);
                check("hold_re", longint'(out_re), er);
                check("hold_im", longint'(out_im), ei);
                start = (k == 4);
                @(posedge clk); #1;
            end
            start = 1'b0;
            out_tready = 1'b1;
        end
        waited = 0;
        while (n_results == base && waited < 400) begin
            @(posedge clk); #1; waited++;
        end
        if (n_results == base) begin
            n_checks++;
            n_fail++;
            $display("FAIL result_timeout: got no result in 400 cycles, required one");
            exp_re_q.delete(); exp_im_q.delete();
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        end else begin
            check("idle_busy", busy, 0);
            check("idle_out_valid", out_tvalid, 0);
            check("retain_re", longint'(out_re), er);
            check("indices_issued", idx_count, BL);
        end
    endtask

    initial begin : sequencer
        int waited;
        longint a, fer, fei;
        out_tready = 1'b1;
        fill_const(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("fs_reset_busy", fs_busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill_const(1, 0, 3, -2);  run_case(0, 0, 0, 0);   // 24 / -16
        fill_const(0, 1, 0, 1);   run_case(0, 0, 0, 0);   // 8 / 0
        fill_const(0, 1, 1, 0);   run_case(0, 0, 0, 0);   // 0 / -8
        for (int t = 0; t < 6; t++) begin
            fill_rand();
            run_case(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 4)), 0);
        end
        fill_const(1, 0, 3, -2);  run_case(1, 1, 3, 0);   // backpressure
        fill_const(1, 0, 3, -2);  run_case(0, 0, 0, 10);  // output stall

        // reset in the middle of a run: nothing queued, nothing may appear
        fill_const(1, 0, 3, -2);
        tog = 1'b1; irand = 1'b0; dly = 0; out_tready = 1'b1;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        waited = 0;
        while (pair_cnt < 3 && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        check("midrun_reached_3_pairs", (pair_cnt >= 3) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midrun_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        run_case(0, 0, 0, 0);

        // full scale on the 1024-sample instance
        fs_start = 1'b1; @(posedge clk); #1; fs_start = 1'b0;
        waited = 0;
        while (!fs_out_tvalid && waited < 1200) begin
            @(posedge clk); #1; waited++;
        end
        a = -2048;
        fer = FS_BL * (a * a + a * a);
        fei = FS_BL * (a * a - a * a);
        check("fs_out_valid", fs_out_tvalid, 1);
        check("fs_out_re", longint'(fs_out_re), fer);
        check("fs_out_im", longint'(fs_out_im), fei);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
